mem_burst_master: RTL and testbench

Initiator for the 8-bit single-port synchronous-read memory. It accepts burst read/write commands from a client (CPU load/store unit, loader, debug port), drives the memory's address, write-data and write-enable pins, and returns read data on a backpressured stream. It hides the memory's one-cycle registered read latency behind a small read FIFO so a burst streams at one byte per cycle.

---
 rtl/edulent_mem_pkg.sv | 29 ++
 rtl/mem_rd_fifo.sv | 93 +++++++++
 rtl/mem_burst_master.sv | 208 ++++++++++++++++++++
 tb/tb_mem_burst_master.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/edulent_mem_pkg.sv
// -----------------------------------------------------------------------------
// edulent_mem_pkg
// Shared widths, burst-master state encoding and the read-return beat format
// used by mem_burst_master and its read FIFO.
// -----------------------------------------------------------------------------
package edulent_mem_pkg;

  localparam int ADDR_W = 8;
  localparam int DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2,
    DRAIN = 2'd3
  } state_t;

  // One entry of the read-return path: data plus end-of-burst marker.
  typedef struct packed {
    logic              last;
    logic [DATA_W-1:0] data;
  } rd_beat_t;

  // Memory addresses wrap modulo 2**ADDR_W.
  function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] a);
    return a + ADDR_W'(1);
  endfunction

endpackage

// File: rtl/mem_rd_fifo.sv
// -----------------------------------------------------------------------------
// mem_rd_fifo
// Small synchronous first-word-fall-through FIFO used to absorb the memory's
// registered read latency. The head entry is visible combinationally.
//
// Ports
//   i_clk, i_rstn   clock, asynchronous active-low reset (empties the FIFO)
//   i_push          write i_push_data (ignored when full)
//   i_push_data     entry to write
//   i_pop           remove head entry (ignored when empty)
//   o_head          current head entry
//   o_count         number of stored entries (0..DEPTH)
//   o_empty/o_full  status flags
// -----------------------------------------------------------------------------
module mem_rd_fifo #(
  parameter int WIDTH = 9,
  parameter int DEPTH = 4
) (
  input  logic                       i_clk,
  input  logic                       i_rstn,
  input  logic                       i_push,
  input  logic [WIDTH-1:0]           i_push_data,
  input  logic                       i_pop,
  output logic [WIDTH-1:0]           o_head,
  output logic [$clog2(DEPTH+1)-1:0] o_count,
  output logic                       o_empty,
  output logic                       o_full
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push;
  logic             do_pop;

  // Pointers wrap explicitly so DEPTH need not be a power of two.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
  endfunction

  assign do_push = i_push && (count_q != FULL_CNT);
  assign do_pop  = i_pop  && (count_q != '0);

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;

    if (do_push) begin
      mem_d[wr_ptr_q] = i_push_data;
      wr_ptr_d        = ptr_inc(wr_ptr_q);
    end
    if (do_pop) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end

    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign o_head  = mem_q[rd_ptr_q];
  assign o_count = count_q;
  assign o_empty = (count_q == '0);
  assign o_full  = (count_q == FULL_CNT);

endmodule

// File: rtl/mem_burst_master.sv
// -----------------------------------------------------------------------------
// mem_burst_master
// Burst initiator for an 8-bit single-port memory with a one-cycle registered
// read port. Write bursts stream one beat per handshake straight to the
// memory pins; read bursts are issued ahead of the consumer and collected in
// a small FIFO so that data streams at one byte per cycle.
//
// Ports
//   i_clk, i_rstn                       clock, asynchronous active-low reset
//   i_cmd_valid/o_cmd_ready             command handshake (ready only in IDLE)
//   i_cmd_write, i_cmd_addr, i_cmd_len  direction, start address, beats-1
//   i_wr_valid/o_wr_ready/i_wr_data     write-data stream
//   o_rd_valid/i_rd_ready/o_rd_data/o_rd_last  read-data stream
//   o_mem_addr, o_mem_data_write, o_mem_write_enable  registered memory pins
//   i_mem_data_read                     memory read data (one cycle after addr)
//   o_busy                              high whenever not IDLE
//   o_done                              one-cycle pulse after a burst completes
// -----------------------------------------------------------------------------
module mem_burst_master
  import edulent_mem_pkg::*;
#(
  parameter int RD_FIFO_DEPTH = 4
) (
  input  logic              i_clk,
  input  logic              i_rstn,

  input  logic              i_cmd_valid,
  output logic              o_cmd_ready,
  input  logic              i_cmd_write,
  input  logic [ADDR_W-1:0] i_cmd_addr,
  input  logic [7:0]        i_cmd_len,

  input  logic              i_wr_valid,
  output logic              o_wr_ready,
  input  logic [DATA_W-1:0] i_wr_data,

  output logic              o_rd_valid,
  input  logic              i_rd_ready,
  output logic [DATA_W-1:0] o_rd_data,
  output logic              o_rd_last,

  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [DATA_W-1:0] o_mem_data_write,
  output logic              o_mem_write_enable,
  input  logic [DATA_W-1:0] i_mem_data_read,

  output logic              o_busy,
  output logic              o_done
);

  localparam int CNT_W = $clog2(RD_FIFO_DEPTH + 1);
  // One extra bit so FIFO count plus two in-flight reads cannot overflow.
  localparam logic [CNT_W:0] DEPTH_LIMIT = (CNT_W + 1)'(RD_FIFO_DEPTH);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        remaining_q, remaining_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              mem_we_q, mem_we_d;
  logic              done_q, done_d;

  // Read pipeline: [0] = address on the memory pins, [1] = data on
  // i_mem_data_read this cycle (pushed into the FIFO at the next edge).
  logic [1:0]        infl_valid_q, infl_valid_d;
  logic [1:0]        infl_last_q, infl_last_d;

  logic              issue;
  logic              issue_last;
  logic              can_issue;
  logic [CNT_W:0]    occupancy;

  logic              fifo_push;
  logic              fifo_pop;
  rd_beat_t          fifo_push_beat;
  rd_beat_t          fifo_head;
  logic [CNT_W-1:0]  fifo_count;
  logic              fifo_empty;
  logic              fifo_full;

  mem_rd_fifo #(
    .WIDTH (DATA_W + 1),
    .DEPTH (RD_FIFO_DEPTH)
  ) u_rd_fifo (
    .i_clk       (i_clk),
    .i_rstn      (i_rstn),
    .i_push      (fifo_push),
    .i_push_data (fifo_push_beat),
    .i_pop       (fifo_pop),
    .o_head      (fifo_head),
    .o_count     (fifo_count),
    .o_empty     (fifo_empty),
    .o_full      (fifo_full)
  );

  assign fifo_push           = infl_valid_q[1];
  assign fifo_push_beat.last = infl_last_q[1];
  assign fifo_push_beat.data = i_mem_data_read;
  assign fifo_pop            = o_rd_valid && i_rd_ready;

  // Reserve a FIFO slot for every read already on its way. A pop in this
  // cycle is deliberately not credited, keeping the issue path free of
  // i_rd_ready.
  assign occupancy = {1'b0, fifo_count}
                   + {{CNT_W{1'b0}}, infl_valid_q[0]}
                   + {{CNT_W{1'b0}}, infl_valid_q[1]};
  assign can_issue = (occupancy < DEPTH_LIMIT);

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    remaining_d = remaining_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_we_d    = 1'b0;
    done_d      = 1'b0;
    issue       = 1'b0;
    issue_last  = 1'b0;

    case (state_q)
      IDLE: begin
        if (i_cmd_valid) begin
          addr_d      = i_cmd_addr;
          remaining_d = i_cmd_len;
          state_d     = i_cmd_write ? WRITE : READ;
        end
      end

      WRITE: begin
        if (i_wr_valid) begin
          mem_addr_d  = addr_q;
          mem_wdata_d = i_wr_data;
          mem_we_d    = 1'b1;
          addr_d      = next_addr(addr_q);
          remaining_d = remaining_q - 8'd1;
          if (remaining_q == 8'd0) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
      end

      READ: begin
        if (can_issue) begin
          issue       = 1'b1;
          mem_addr_d  = addr_q;
          addr_d      = next_addr(addr_q);
          remaining_d = remaining_q - 8'd1;
          if (remaining_q == 8'd0) begin
            issue_last = 1'b1;
            state_d    = DRAIN;
          end
        end
      end

      DRAIN: begin
        if (fifo_pop && fifo_head.last) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end

      default: state_d = IDLE;
    endcase

    infl_valid_d = {infl_valid_q[0], issue};
    infl_last_d  = {infl_last_q[0], issue_last};
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_q      <= IDLE;
      addr_q       <= '0;
      remaining_q  <= '0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      mem_we_q     <= 1'b0;
      done_q       <= 1'b0;
      infl_valid_q <= '0;
      infl_last_q  <= '0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      remaining_q  <= remaining_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      mem_we_q     <= mem_we_d;
      done_q       <= done_d;
      infl_valid_q <= infl_valid_d;
      infl_last_q  <= infl_last_d;
    end
  end

  assign o_cmd_ready        = (state_q == IDLE);
  assign o_wr_ready         = (state_q == WRITE);
  assign o_busy             = (state_q != IDLE);
  assign o_done             = done_q;

  assign o_mem_addr         = mem_addr_q;
  assign o_mem_data_write   = mem_wdata_q;
  assign o_mem_write_enable = mem_we_q;

  // Stale FIFO contents are masked so the stream reads as zero when idle.
  assign o_rd_valid         = !fifo_empty;
  assign o_rd_data          = o_rd_valid ? fifo_head.data : '0;
  assign o_rd_last          = o_rd_valid && fifo_head.last;

endmodule

// File: tb/tb_mem_burst_master.sv
module tb_mem_burst_master;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_write = 1'b0;
  logic [7:0] cmd_addr = '0;
  logic [7:0] cmd_len = '0;
  logic       wr_valid = 1'b0;
  logic [7:0] wr_data = '0;
  logic       rd_ready = 1'b0;
  logic       o_cmd_ready, o_wr_ready, o_rd_valid, o_rd_last;
  logic [7:0] o_rd_data, o_mem_addr, o_mem_data_write;
  logic       o_mem_write_enable, o_busy, o_done;
  logic [7:0] mem_rdata;

  always #5 clk = ~clk;

  mem_burst_master #(.RD_FIFO_DEPTH(4)) dut (
    .i_clk              (clk),
    .i_rstn             (rstn),
    .i_cmd_valid        (cmd_valid),
    .o_cmd_ready        (o_cmd_ready),
    .i_cmd_write        (cmd_write),
    .i_cmd_addr         (cmd_addr),
    .i_cmd_len          (cmd_len),
    .i_wr_valid         (wr_valid),
    .o_wr_ready         (o_wr_ready),
    .i_wr_data          (wr_data),
    .o_rd_valid         (o_rd_valid),
    .i_rd_ready         (rd_ready),
    .o_rd_data          (o_rd_data),
    .o_rd_last          (o_rd_last),
    .o_mem_addr         (o_mem_addr),
    .o_mem_data_write   (o_mem_data_write),
    .o_mem_write_enable (o_mem_write_enable),
    .i_mem_data_read    (mem_rdata),
    .o_busy             (o_busy),
    .o_done             (o_done)
  );

  // Behavioural single-port memory with a registered read port.
  logic [7:0] dev_mem [256];
  logic       preload = 1'b1;

  function automatic logic [7:0] init_val(input int i);
    return 8'((i * 73 + 29) ^ (i >> 3));
  endfunction

  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 256; i++) dev_mem[i] <= init_val(i);
    end else begin
      mem_rdata <= dev_mem[o_mem_addr];
      if (o_mem_write_enable) dev_mem[o_mem_addr] <= o_mem_data_write;
    end
  end

  int cyc = 0;
  int we_cnt = 0;
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (o_mem_write_enable) we_cnt <= we_cnt + 1;
  end

  // Reference model: expected memory image.
  logic [7:0] ref_mem [256];
  logic [7:0] wbuf [256];
  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_outputs(input string pfx);
    check({pfx, "_cmd_ready"}, o_cmd_ready, 1);
    check({pfx, "_wr_ready"}, o_wr_ready, 0);
    check({pfx, "_rd_valid"}, o_rd_valid, 0);
    check({pfx, "_rd_last"}, o_rd_last, 0);
    check({pfx, "_rd_data"}, o_rd_data, 0);
    check({pfx, "_mem_addr"}, o_mem_addr, 0);
    check({pfx, "_mem_wdata"}, o_mem_data_write, 0);
    check({pfx, "_mem_we"}, o_mem_write_enable, 0);
    check({pfx, "_busy"}, o_busy, 0);
    check({pfx, "_done"}, o_done, 0);
  endtask

  // Drives a command and returns the cycle index of its handshake.
  task automatic send_cmd(input logic wr, input logic [7:0] a, input logic [7:0] len,
                          output int hs);
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = a; cmd_len = len;
    hs = -1;
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      if (o_cmd_ready) begin hs = cyc; break; end
      @(posedge clk); #1;
    end
    if (hs < 0) check("cmd_timeout", 0, 1);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  // Write burst of len+1 bytes from wbuf. gap: wr_valid every other cycle.
  // mid_cmd: hold a read command on i_cmd_valid during the first beats.
  // abort_after >= 0: reset the DUT once that many beats have been written.
  task automatic write_burst(input logic [7:0] a, input logic [7:0] len, input bit gap,
                             input bit mid_cmd, input int abort_after);
    int hs, k, prev_idx, we0;
    logic prev_acc;
    send_cmd(1'b1, a, len, hs);
    we0 = we_cnt;
    k = 0; prev_acc = 1'b0; prev_idx = 0;
    for (int n = 0; n < 600 && k <= int'(len); n++) begin
      wr_valid = gap ? (n % 2 == 1) : 1'b1;
      wr_data  = wbuf[k];
      if (mid_cmd) begin
        cmd_valid = (k < 2); cmd_write = 1'b0; cmd_addr = 8'h77; cmd_len = 8'd1;
      end
      @(negedge clk);
      check("wr_we_timing", o_mem_write_enable, prev_acc);
      if (prev_acc) begin
        check("wr_mem_addr", o_mem_addr, 8'(a + prev_idx));
        check("wr_mem_data", o_mem_data_write, wbuf[prev_idx]);
      end
      check("wr_ready", o_wr_ready, 1);
      if (cmd_valid) check("cmd_ready_while_busy", o_cmd_ready, 0);
      prev_acc = wr_valid && o_wr_ready;
      if (prev_acc) begin prev_idx = k; k++; end
      if (abort_after >= 0 && k == abort_after) break;
      @(posedge clk); #1;
    end
    cmd_valid = 1'b0;
    if (abort_after >= 0) begin
      @(posedge clk); #1;
      wr_valid = 1'b0;
      @(negedge clk);
      check("abort_we", o_mem_write_enable, 1);
      check("abort_done", o_done, 0);
      @(posedge clk); #1;
      rstn = 1'b0;
      #1;
      check_reset_outputs("midrst");
      for (int i = 0; i < abort_after; i++) ref_mem[8'(a + i)] = wbuf[i];
      @(posedge clk); @(posedge clk); #1;
      rstn = 1'b1;
      @(negedge clk);
      check("post_rst_cmd_ready", o_cmd_ready, 1);
      check("post_rst_busy", o_busy, 0);
      @(posedge clk); #1;
      return;
    end
    wr_valid = 1'b0;
    if (k <= int'(len)) check("wr_timeout", k, int'(len) + 1);
    @(negedge clk);
    check("wr_last_we", o_mem_write_enable, 1);
    check("wr_done", o_done, 1);
    check("wr_cmd_ready", o_cmd_ready, 1);
    @(posedge clk); #1;
    @(negedge clk);
    check("wr_done_pulse", o_done, 0);
    check("wr_we_count", we_cnt - we0, int'(len) + 1);
    for (int i = 0; i <= int'(len); i++) ref_mem[8'(a + i)] = wbuf[i];
    @(posedge clk); #1;
  endtask

  // Read burst. mode 0: ready always high; 1: ready low for 10 cycles after
  // the first beat; 2: random ready.
  task automatic read_burst(input logic [7:0] a, input logic [7:0] len, input int mode);
    int hs, k, first_valid, last_pop, stall_left;
    logic [7:0] held;
    send_cmd(1'b0, a, len, hs);
    k = 0; first_valid = -1; last_pop = -1; stall_left = 0; held = '0;
    for (int n = 0; n < 3000 && k <= int'(len); n++) begin
      case (mode)
        0:       rd_ready = 1'b1;
        1:       rd_ready = (stall_left == 0);
        default: rd_ready = ($urandom_range(0, 3) != 0);
      endcase
      @(negedge clk);
      if (mode == 1 && stall_left > 0) begin
        check("stall_rd_valid", o_rd_valid, 1);
        if (stall_left == 6) held = o_mem_addr;
        if (stall_left == 1) begin
          check("stall_addr_limit", o_mem_addr, 8'(a + 4));
          check("stall_addr_held", o_mem_addr, held);
        end
        stall_left--;
      end
      if (o_rd_valid) begin
        if (first_valid < 0) begin
          first_valid = cyc;
          if (mode == 0) check("rd_first_latency", cyc - hs, 4);
        end
        if (rd_ready) begin
          check("rd_data", o_rd_data, ref_mem[8'(a + k)]);
          check("rd_last", o_rd_last, (k == int'(len)));
          k++;
          last_pop = cyc;
          if (mode == 1 && k == 1) stall_left = 10;
        end
      end
      @(posedge clk); #1;
    end
    rd_ready = 1'b0;
    if (k <= int'(len)) check("rd_timeout", k, int'(len) + 1);
    if (mode == 0) check("rd_last_pop_cycle", last_pop - hs, 4 + int'(len));
    @(negedge clk);
    check("rd_done", o_done, 1);
    check("rd_cmd_ready", o_cmd_ready, 1);
    check("rd_empty_after", o_rd_valid, 0);
    @(posedge clk); #1;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int bad;
    logic [7:0] ra, rl;
    for (int i = 0; i < 256; i++) ref_mem[i] = init_val(i);
    repeat (3) @(posedge clk);
    #1;
    preload = 1'b0;
    check_reset_outputs("reset");
    rstn = 1'b1;
    @(posedge clk); #1;

    // Single-byte write then read back.
    wbuf[0] = 8'hA5;
    write_burst(8'h10, 8'd0, 1'b0, 1'b0, -1);
    check("mem_0x10", dev_mem[8'h10], 8'hA5);
    read_burst(8'h10, 8'd0, 0);

    // Wrapping 4-byte write and read.
    for (int i = 0; i < 4; i++) wbuf[i] = 8'(i + 1);
    write_burst(8'hFE, 8'd3, 1'b0, 1'b0, -1);
    check("mem_0xFE", dev_mem[8'hFE], 8'd1);
    check("mem_0xFF", dev_mem[8'hFF], 8'd2);
    check("mem_0x00", dev_mem[8'h00], 8'd3);
    check("mem_0x01", dev_mem[8'h01], 8'd4);
    read_burst(8'hFE, 8'd3, 0);

    // 16-byte streaming read, then 8-byte read with backpressure.
    read_burst(8'($urandom_range(0, 255)), 8'd15, 0);
    read_burst(8'h80, 8'd7, 1);

    // Gapped write with a command held during the burst.
    for (int i = 0; i < 4; i++) wbuf[i] = 8'($urandom);
    write_burst(8'h30, 8'd3, 1'b1, 1'b1, -1);
    read_burst(8'h30, 8'd3, 0);

    // Randomized write/read traffic.
    for (int t = 0; t < 6; t++) begin
      ra = 8'($urandom);
      rl = 8'($urandom_range(0, 15));
      for (int i = 0; i <= int'(rl); i++) wbuf[i] = 8'($urandom);
      write_burst(ra, rl, 1'($urandom_range(0, 1)), 1'b0, -1);
      read_burst(8'(ra - 8'($urandom_range(0, 3))), 8'($urandom_range(0, 23)), 2);
      read_burst(8'($urandom), 8'($urandom_range(0, 20)), $urandom_range(0, 1) * 2);
    end

    // Reset after 2 of 4 write beats.
    for (int i = 0; i < 4; i++) wbuf[i] = 8'($urandom);
    write_burst(8'h60, 8'd3, 1'b0, 1'b0, 2);
    check("rst_mem_0x60", dev_mem[8'h60], wbuf[0]);
    check("rst_mem_0x61", dev_mem[8'h61], wbuf[1]);
    check("rst_mem_0x62", dev_mem[8'h62], ref_mem[8'h62]);
    check("rst_mem_0x63", dev_mem[8'h63], ref_mem[8'h63]);
    read_burst(8'h5F, 8'd5, 0);

    // Whole memory image against the model.
    bad = 0;
    for (int i = 0; i < 256; i++) if (dev_mem[i] !== ref_mem[i]) bad++;
    check("mem_image_mismatches", bad, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
